// File: rtl/stream_demux_n_pkg.sv
// Shared constants and helpers for the parametrised bus demux blocks.
package stream_demux_n_pkg;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Select width for an n-way block; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             rdy,
    output logic [WIDTH-1:0] q,
    output logic             vld,
    output logic             free_o
);

    // A draining slot can accept a new beat on the same edge.
    assign free_o = !vld || rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            q   <= d;
            vld <= 1'b1;
        end else if (rdy && vld) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_n.sv
// 1-to-NUM_OUT valid/ready demux with per-channel holding slots, broadcast and bad-select accounting.
module stream_demux_n
    import stream_demux_n_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 2,
    localparam int SEL_W  = sel_width(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic                     sel_err,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int SEL_SPAN = 2 ** SEL_W;

    logic [NUM_OUT-1:0]  free;
    logic [NUM_OUT-1:0]  load;
    logic [SEL_SPAN-1:0] free_ext;
    logic                sel_ok;
    logic                accept;
    logic                drop;

    // Zero-padded so an out-of-range select never indexes past the vector.
    assign free_ext = SEL_SPAN'(free);

    generate
        if (SEL_SPAN == NUM_OUT) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_part
            assign sel_ok = (in_sel < SEL_W'(NUM_OUT));
        end
    endgenerate

    always_comb begin
        in_ready = 1'b0;
        if (rst_n && !flush) begin
            if (in_bcast)
                in_ready = &free;
            else if (sel_ok)
                in_ready = free_ext[in_sel];
            else
                in_ready = 1'b1;
        end
    end

    assign accept = in_valid && in_ready;
    assign drop   = accept && !in_bcast && !sel_ok;

    genvar i;
    generate
        for (i = 0; i < NUM_OUT; i++) begin : g_slot
            assign load[i] = accept && (in_bcast || (sel_ok && in_sel == SEL_W'(i)));

            demux_slot #(.WIDTH(WIDTH)) u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .flush  (flush),
                .load   (load[i]),
                .d      (in_data),
                .rdy    (out_ready[i]),
                .q      (out_data[i*WIDTH +: WIDTH]),
                .vld    (out_valid[i]),
                .free_o (free[i])
            );
        end
    endgenerate

    // Error count survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            sel_err <= drop;
            if (drop && err_cnt != ERR_CNT_MAX)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed-vector bench for stream_demux_n with WIDTH=16, NUM_OUT=3.
module tb_stream_demux_n;

    localparam int W = 16;
    localparam int N = 3;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [W-1:0]    in_data;
    logic [1:0]      in_sel;
    logic            in_bcast;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic            sel_err;
    logic [7:0]      err_cnt;

    int nvec = 0;
    int nerr = 0;

    stream_demux_n #(.WIDTH(W), .NUM_OUT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        logic [1:0]   s;

        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_sel = '0;
        in_bcast = 1'b0; in_valid = 1'b0; out_ready = '0;
        #2;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data",  64'(out_data),  64'h0);
        chk("rst_ready", 64'(in_ready),  64'h0);
        chk("rst_cnt",   64'(err_cnt),   64'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'h1);

        // Unicast with backpressure on channel 1
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'hA5A5;
        #1 chk("uni_ready0", 64'(in_ready), 64'h1);
        step();
        chk("uni_valid", 64'(out_valid), 64'h2);
        chk("uni_data",  64'(out_data[31:16]), 64'hA5A5);
        in_data = 16'h1234;
        #1 chk("bp_ready", 64'(in_ready), 64'h0);
        step();
        chk("bp_hold_valid", 64'(out_valid), 64'h2);
        chk("bp_hold_data",  64'(out_data[31:16]), 64'hA5A5);
        out_ready = 3'b010;
        #1 chk("bp_release", 64'(in_ready), 64'h1);
        step();
        chk("drain_load_valid", 64'(out_valid), 64'h2);
        chk("drain_load_data",  64'(out_data[31:16]), 64'h1234);
        in_valid = 1'b0;
        step();
        chk("drained", 64'(out_valid), 64'h0);

        // Full-throughput round robin
        out_ready = 3'b111;
        for (int k = 0; k < 8; k++) begin
            s = 2'(k % 3);
            d = 16'h0100 + 16'(k);
            in_valid = 1'b1; in_sel = s; in_data = d;
            #1 chk("tp_ready", 64'(in_ready), 64'h1);
            step();
            chk("tp_valid", 64'(out_valid), 64'(1 << s));
            chk("tp_data",  64'(out_data[s*W +: W]), 64'(d));
        end
        in_valid = 1'b0;
        step();
        chk("tp_empty", 64'(out_valid), 64'h0);

        // Broadcast blocked by a full slot, then released
        out_ready = 3'b000;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 16'h2222;
        step();
        in_bcast = 1'b1; in_data = 16'hBEEF;
        #1 chk("bc_blocked", 64'(in_ready), 64'h0);
        step();
        chk("bc_not_taken", 64'(out_valid), 64'h4);
        out_ready = 3'b100;
        #1 chk("bc_ready", 64'(in_ready), 64'h1);
        step();
        out_ready = 3'b000; in_valid = 1'b0; in_bcast = 1'b0;
        chk("bc_valid", 64'(out_valid), 64'h7);
        chk("bc_data",  64'(out_data), 64'hBEEF_BEEF_BEEF);
        out_ready = 3'b111;
        step();
        out_ready = 3'b000;
        chk("bc_drained", 64'(out_valid), 64'h0);

        // Out-of-range select
        in_valid = 1'b1; in_sel = 2'd3; in_data = 16'h0F0F;
        #1 chk("err_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("err_noload", 64'(out_valid), 64'h0);
        chk("err_pulse",  64'(sel_err), 64'h1);
        chk("err_cnt1",   64'(err_cnt), 64'h1);
        step();
        chk("err_pulse_end", 64'(sel_err), 64'h0);
        chk("err_cnt_hold",  64'(err_cnt), 64'h1);
        in_valid = 1'b1;
        for (int k = 0; k < 299; k++) step();
        chk("err_sat", 64'(err_cnt), 64'd255);
        in_valid = 1'b0;
        step();
        chk("err_sat_hold", 64'(err_cnt), 64'd255);
        chk("err_no_pulse", 64'(sel_err), 64'h0);

        // Flush with slots 0 and 2 full
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h0AAA;
        step();
        in_sel = 2'd2; in_data = 16'h0CCC;
        step();
        chk("fl_pre", 64'(out_valid), 64'h5);
        flush = 1'b1; in_sel = 2'd0; in_data = 16'h5555;
        #1 chk("fl_ready", 64'(in_ready), 64'h0);
        step();
        chk("fl_valid", 64'(out_valid), 64'h0);
        chk("fl_keep_data", 64'(out_data[15:0]), 64'h0AAA);
        chk("fl_cnt", 64'(err_cnt), 64'd255);
        flush = 1'b0;
        #1 chk("fl_after_ready", 64'(in_ready), 64'h1);
        step();
        chk("fl_after_valid", 64'(out_valid), 64'h1);
        chk("fl_after_data",  64'(out_data[15:0]), 64'h5555);

        // Asynchronous reset with slots full
        in_sel = 2'd1; in_data = 16'h7777;
        step();
        in_valid = 1'b0;
        chk("ar_pre", 64'(out_valid), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'h0);
        chk("ar_data",  64'(out_data),  64'h0);
        chk("ar_cnt",   64'(err_cnt),   64'h0);
        chk("ar_ready", 64'(in_ready),  64'h0);
        chk("ar_err",   64'(sel_err),   64'h0);
        step();
        rst_n = 1'b1; in_sel = 2'd0; in_valid = 1'b1;
        #1 chk("ar_release", 64'(in_ready), 64'h1);
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
